// File: rtl/id_stage_if.sv
// Decode-stage pipeline bus: fetch/write-back inputs and ID/EX outputs.
// The slave side is the decode stage; the master side drives it.
interface id_stage_if;
   logic [31:0] ip_instruction;
   logic [9:0]  ip_PC_plus_4;
   logic        ip_flush;
   logic        ip_reg_write;
   logic [4:0]  ip_write_reg_addr;
   logic [31:0] ip_write_data;

   logic        op_stall;
   logic [31:0] op_read_data_1;
   logic [31:0] op_read_data_2;
   logic [31:0] op_sign_extend;
   logic [4:0]  op_rs;
   logic [4:0]  op_rt;
   logic [4:0]  op_rd;
   logic [9:0]  op_PC_plus_4;
   logic        op_reg_dst;
   logic        op_alu_src;
   logic        op_mem_to_reg;
   logic        op_reg_write;
   logic        op_mem_read;
   logic        op_mem_write;
   logic        op_branch;
   logic [1:0]  op_alu_op;

   modport master (
      output ip_instruction, ip_PC_plus_4, ip_flush, ip_reg_write, ip_write_reg_addr, ip_write_data,
      input  op_stall, op_read_data_1, op_read_data_2, op_sign_extend, op_rs, op_rt, op_rd,
             op_PC_plus_4, op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write, op_mem_read,
             op_mem_write, op_branch, op_alu_op
   );

   modport slave (
      input  ip_instruction, ip_PC_plus_4, ip_flush, ip_reg_write, ip_write_reg_addr, ip_write_data,
      output op_stall, op_read_data_1, op_read_data_2, op_sign_extend, op_rs, op_rt, op_rd,
             op_PC_plus_4, op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write, op_mem_read,
             op_mem_write, op_branch, op_alu_op
   );
endinterface

// File: rtl/id_stage.sv
// MIPS-style instruction decode stage: register file with write-through bypass,
// control decode, load-use stall detection and the ID/EX pipeline register.
module id_stage #(
   parameter int REGS_INIT_INDEX = 1
) (
   input logic      clock,
   input logic      reset,
   id_stage_if.slave bus
);

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   logic [31:0] regs_q [32];

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rdata1, rdata2, sext;
   ctrl_t       ctrl_d;
   logic        stall;

   ctrl_t       ctrl_q;
   logic [31:0] rd1_q, rd2_q, sext_q;
   logic [4:0]  rs_q, rt_q, rd_q;
   logic [9:0]  pc4_q;

   assign opcode = bus.ip_instruction[31:26];
   assign rs     = bus.ip_instruction[25:21];
   assign rt     = bus.ip_instruction[20:16];
   assign rd     = bus.ip_instruction[15:11];
   assign sext   = {{16{bus.ip_instruction[15]}}, bus.ip_instruction[15:0]};

   // Reset doubles as the write-port block: no write can land while it is held.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++)
            regs_q[i] <= (REGS_INIT_INDEX != 0) ? 32'(i) : 32'd0;
      end else if (bus.ip_reg_write && bus.ip_write_reg_addr != 5'd0) begin
         regs_q[bus.ip_write_reg_addr] <= bus.ip_write_data;
      end
   end

   always_comb begin
      rdata1 = regs_q[rs];
      if (rs == 5'd0)
         rdata1 = '0;
      else if (bus.ip_reg_write && bus.ip_write_reg_addr == rs)
         rdata1 = bus.ip_write_data;
   end

   always_comb begin
      rdata2 = regs_q[rt];
      if (rt == 5'd0)
         rdata2 = '0;
      else if (bus.ip_reg_write && bus.ip_write_reg_addr == rt)
         rdata2 = bus.ip_write_data;
   end

   always_comb begin
      ctrl_d = '0;
      case (opcode)
         OP_RTYPE: begin
            // All-zero word is the canonical nop and must not look like a real op.
            if (bus.ip_instruction != 32'd0) begin
               ctrl_d.reg_dst   = 1'b1;
               ctrl_d.reg_write = (rd != 5'd0);
               ctrl_d.alu_op    = 2'b10;
            end
         end
         OP_LW: begin
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_read   = 1'b1;
         end
         OP_SW: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = 2'b01;
         end
         OP_ADDI: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
         end
         default: ctrl_d = '0;
      endcase
   end

   // Load in EX whose destination feeds the instruction now in decode.
   assign stall = ctrl_q.mem_read && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         sext_q <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
         pc4_q  <= '0;
      end else begin
         ctrl_q <= (bus.ip_flush || stall) ? ctrl_t'('0) : ctrl_d;
         rd1_q  <= rdata1;
         rd2_q  <= rdata2;
         sext_q <= sext;
         rs_q   <= rs;
         rt_q   <= rt;
         rd_q   <= rd;
         pc4_q  <= bus.ip_PC_plus_4;
      end
   end

   assign bus.op_stall       = stall;
   assign bus.op_read_data_1 = rd1_q;
   assign bus.op_read_data_2 = rd2_q;
   assign bus.op_sign_extend = sext_q;
   assign bus.op_rs          = rs_q;
   assign bus.op_rt          = rt_q;
   assign bus.op_rd          = rd_q;
   assign bus.op_PC_plus_4   = pc4_q;
   assign bus.op_reg_dst     = ctrl_q.reg_dst;
   assign bus.op_alu_src     = ctrl_q.alu_src;
   assign bus.op_mem_to_reg  = ctrl_q.mem_to_reg;
   assign bus.op_reg_write   = ctrl_q.reg_write;
   assign bus.op_mem_read    = ctrl_q.mem_read;
   assign bus.op_mem_write   = ctrl_q.mem_write;
   assign bus.op_branch      = ctrl_q.branch;
   assign bus.op_alu_op      = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use stall, flush and reset.
module tb_id_stage;
   logic clock;
   logic reset;
   int   errors;
   int   checks;

   id_stage_if bus();

   id_stage #(.REGS_INIT_INDEX(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
   logic [8:0] ctrl;
   assign ctrl = {bus.op_reg_dst, bus.op_alu_src, bus.op_mem_to_reg, bus.op_reg_write,
                  bus.op_mem_read, bus.op_mem_write, bus.op_branch, bus.op_alu_op};

   localparam logic [8:0] C_R    = 9'b100100010;
   localparam logic [8:0] C_LW   = 9'b011110000;
   localparam logic [8:0] C_SW   = 9'b010001000;
   localparam logic [8:0] C_BEQ  = 9'b000000101;
   localparam logic [8:0] C_ADDI = 9'b010100000;
   localparam logic [8:0] C_NONE = 9'b000000000;

   localparam logic [31:0] I_ADD = 32'h00430820;  // add $1,$2,$3
   localparam logic [31:0] I_LW  = 32'h8C090000;  // lw  $9,0($0)
   localparam logic [31:0] I_OR  = 32'h01210825;  // or  $1,$9,$1

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.ip_instruction = '0; bus.ip_PC_plus_4 = '0; bus.ip_flush = 1'b0;
      bus.ip_reg_write = 1'b0; bus.ip_write_reg_addr = '0; bus.ip_write_data = '0;
      #3;
      checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_NONE); end
      checks++; if (bus.op_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.op_stall); end
      checks++; if (bus.op_read_data_1 !== 32'd0 || bus.op_sign_extend !== 32'd0 || bus.op_PC_plus_4 !== 10'd0)
         begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.op_read_data_1, bus.op_sign_extend, bus.op_PC_plus_4); end
      step();
      checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_held got=%b exp=%b", ctrl, C_NONE); end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_rtype();
      bus.ip_instruction = I_ADD; bus.ip_PC_plus_4 = 10'h004;
      step();
      checks++; if (bus.op_read_data_1 !== 32'd2) begin errors++; $display("FAIL add_rd1 got=%h exp=2", bus.op_read_data_1); end
      checks++; if (bus.op_read_data_2 !== 32'd3) begin errors++; $display("FAIL add_rd2 got=%h exp=3", bus.op_read_data_2); end
      checks++; if (bus.op_rd !== 5'd1 || bus.op_rs !== 5'd2 || bus.op_rt !== 5'd3)
         begin errors++; $display("FAIL add_fields got=%0d/%0d/%0d exp=2/3/1", bus.op_rs, bus.op_rt, bus.op_rd); end
      checks++; if (ctrl !== C_R) begin errors++; $display("FAIL add_ctrl got=%b exp=%b", ctrl, C_R); end
      checks++; if (bus.op_PC_plus_4 !== 10'h004) begin errors++; $display("FAIL add_pc got=%h exp=004", bus.op_PC_plus_4); end
   endtask

   task automatic test_load_use_bypass();
      @(negedge clock);
      bus.ip_instruction = I_LW;
      step();
      checks++; if (ctrl !== C_LW) begin errors++; $display("FAIL lw_ctrl got=%b exp=%b", ctrl, C_LW); end
      checks++; if (bus.op_rt !== 5'd9) begin errors++; $display("FAIL lw_rt got=%0d exp=9", bus.op_rt); end
      @(negedge clock);
      bus.ip_instruction = I_OR;
      bus.ip_reg_write = 1'b1; bus.ip_write_reg_addr = 5'd9; bus.ip_write_data = 32'h55555555;
      #1;
      checks++; if (bus.op_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", bus.op_stall); end
      step();
      checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL lu_bubble got=%b exp=%b", ctrl, C_NONE); end
      checks++; if (bus.op_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got=%b exp=0", bus.op_stall); end
      checks++; if (bus.op_read_data_1 !== 32'h55555555) begin errors++; $display("FAIL bypass_rd1 got=%h exp=55555555", bus.op_read_data_1); end
      @(negedge clock);
      bus.ip_reg_write = 1'b0;
      step();
      checks++; if (ctrl !== C_R) begin errors++; $display("FAIL or_ctrl got=%b exp=%b", ctrl, C_R); end
      checks++; if (bus.op_read_data_1 !== 32'h55555555 || bus.op_read_data_2 !== 32'd1)
         begin errors++; $display("FAIL or_data got=%h/%h exp=55555555/1", bus.op_read_data_1, bus.op_read_data_2); end
      checks++; if (bus.op_stall !== 1'b0) begin errors++; $display("FAIL or_stall got=%b exp=0", bus.op_stall); end
   endtask

   task automatic test_zero_reg();
      @(negedge clock);
      bus.ip_instruction = 32'h00000820;  // add $1,$0,$0
      bus.ip_reg_write = 1'b1; bus.ip_write_reg_addr = 5'd0; bus.ip_write_data = 32'hFFFFFFFF;
      step();
      checks++; if (bus.op_read_data_1 !== 32'd0) begin errors++; $display("FAIL zero_bypass got=%h exp=0", bus.op_read_data_1); end
      @(negedge clock);
      bus.ip_reg_write = 1'b0;
      step();
      checks++; if (bus.op_read_data_1 !== 32'd0 || bus.op_read_data_2 !== 32'd0)
         begin errors++; $display("FAIL zero_read got=%h/%h exp=0/0", bus.op_read_data_1, bus.op_read_data_2); end
   endtask

   task automatic test_decode();
      @(negedge clock);
      bus.ip_instruction = 32'hAC0A0004;  // sw $10,4($0)
      step();
      checks++; if (ctrl !== C_SW) begin errors++; $display("FAIL sw_ctrl got=%b exp=%b", ctrl, C_SW); end
      checks++; if (bus.op_sign_extend !== 32'd4 || bus.op_read_data_2 !== 32'd10)
         begin errors++; $display("FAIL sw_data got=%h/%h exp=4/a", bus.op_sign_extend, bus.op_read_data_2); end
      @(negedge clock);
      bus.ip_instruction = 32'h2002FFF0;  // addi $2,$0,-16
      step();
      checks++; if (ctrl !== C_ADDI) begin errors++; $display("FAIL addi_ctrl got=%b exp=%b", ctrl, C_ADDI); end
      checks++; if (bus.op_sign_extend !== 32'hFFFFFFF0) begin errors++; $display("FAIL addi_sext got=%h exp=fffffff0", bus.op_sign_extend); end
      @(negedge clock);
      bus.ip_instruction = 32'hFC000000;
      step();
      checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL unk_ctrl got=%b exp=%b", ctrl, C_NONE); end
      @(negedge clock);
      bus.ip_instruction = 32'h00000000;
      step();
      checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL nop_ctrl got=%b exp=%b", ctrl, C_NONE); end
   endtask

   task automatic test_flush();
      @(negedge clock);
      bus.ip_instruction = I_LW; bus.ip_flush = 1'b1;
      step();
      checks++; if (bus.op_mem_read !== 1'b0 || bus.op_reg_write !== 1'b0)
         begin errors++; $display("FAIL flush_lw got=%b%b exp=00", bus.op_mem_read, bus.op_reg_write); end
      @(negedge clock);
      bus.ip_flush = 1'b0;
      step();
      checks++; if (ctrl !== C_LW) begin errors++; $display("FAIL flush_relw got=%b exp=%b", ctrl, C_LW); end
      @(negedge clock);
      bus.ip_instruction = I_OR; bus.ip_flush = 1'b1;
      #1;
      checks++; if (bus.op_stall !== 1'b1) begin errors++; $display("FAIL fs_stall got=%b exp=1", bus.op_stall); end
      step();
      checks++; if (ctrl !== C_NONE) begin errors++; $display("FAIL fs_bubble got=%b exp=%b", ctrl, C_NONE); end
      @(negedge clock);
      bus.ip_flush = 1'b0;
      step();
      checks++; if (ctrl !== C_R || bus.op_stall !== 1'b0)
         begin errors++; $display("FAIL fs_single got=%b/%b exp=%b/0", ctrl, bus.op_stall, C_R); end
   endtask

   task automatic test_beq_async_reset();
      @(negedge clock);
      bus.ip_instruction = 32'h1021FFFF; bus.ip_PC_plus_4 = 10'h3A4;
      step();
      checks++; if (ctrl !== C_BEQ) begin errors++; $display("FAIL beq_ctrl got=%b exp=%b", ctrl, C_BEQ); end
      checks++; if (bus.op_sign_extend !== 32'hFFFFFFFF || bus.op_PC_plus_4 !== 10'h3A4)
         begin errors++; $display("FAIL beq_data got=%h/%h exp=ffffffff/3a4", bus.op_sign_extend, bus.op_PC_plus_4); end
      #1 reset = 1'b0;
      #1;
      checks++; if (ctrl !== C_NONE || bus.op_sign_extend !== 32'd0 || bus.op_PC_plus_4 !== 10'd0 || bus.op_rt !== 5'd0)
         begin errors++; $display("FAIL async_reset got=%b/%h/%h exp=0", ctrl, bus.op_sign_extend, bus.op_PC_plus_4); end
      // Write attempted under reset must not land in $9.
      bus.ip_reg_write = 1'b1; bus.ip_write_reg_addr = 5'd9; bus.ip_write_data = 32'hDEADBEEF;
      step();
      @(negedge clock);
      bus.ip_reg_write = 1'b0;
      reset = 1'b1;
      bus.ip_instruction = 32'h01220820;  // add $1,$9,$2
      step();
      checks++; if (ctrl !== C_R) begin errors++; $display("FAIL post_reset_ctrl got=%b exp=%b", ctrl, C_R); end
      checks++; if (bus.op_read_data_1 !== 32'd9 || bus.op_read_data_2 !== 32'd2)
         begin errors++; $display("FAIL post_reset_regs got=%h/%h exp=9/2", bus.op_read_data_1, bus.op_read_data_2); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_rtype();
      test_load_use_bypass();
      test_zero_reg();
      test_decode();
      test_flush();
      test_beq_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
